k1_pulse_checker: RTL and testbench
===================================

# k1_pulse_checker

Test-side monitor for the K1 trigger-pulse interface. It watches the same TEM trigger that the K1 pulse generator sees and the K1 pulse that generator returns. For each trigger it measures the trigger-to-K1 latency and the K1 high width, classifies the result against configured limits and reports it as a one-cycle result strobe. It sits on the PCB-test side as the receiving end of the K1 pulse path and feeds result registers and the pass/fail indicators.

## Interface
- `LAT_MAX`, 8: largest passing latency, in clk cycles.
- `WIDTH_MIN`, 795: smallest passing K1 width, in clk cycles.
- `WIDTH_MAX`, 805: largest passing K1 width, in clk cycles.
- `TIMEOUT`, 4096: limit for waiting on K1 and for K1 stuck high; must be < 65536.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: checker run enable.
- `tem` input 1: trigger, same net that drives the K1 generator.
- `k1_in` input 1: K1 pulse under test.
- `meas_valid` output 1: one-cycle strobe; results below are valid and updated.
- `latency` output 16: trigger-to-K1 cycles of the last report.
- `width` output 32: K1 high cycles of the last report.
- `pass` output 1: last report passed (`err_code` == 0).
- `err_code` output 3: 0 OK, 1 NO_RESP, 2 TOO_LONG, 3 TOO_SHORT, 4 LATE, 5 SPURIOUS.
- `pulse_count` output 16: passing reports since reset; saturates at 0xFFFF.

## Operation
- **Edge detect.** Inputs are sampled on every clk rising edge. A rise is detected when the current sample is 1 and the previous sample is 0.
- **IDLE**
  - tem rise: go to ARMED with `lat_cnt` = 0.
  - k1 rise without a tem rise: go to HIGH with spurious flag set, `lat_cnt` = 0.
  - tem rise and k1 rise on the same edge: go to HIGH with latency 0 and spurious clear.
- **ARMED**
  - `lat_cnt` increments each cycle.
  - k1 rise: go to HIGH, latch `latency` = cycles since the tem rise, `wid_cnt` = 1.
  - `lat_cnt` == TIMEOUT: go to REPORT with NO_RESP and width 0.
  - A further tem rise is ignored.
- **HIGH**
  - `wid_cnt` increments while k1 is sampled high.
  - k1 sampled low: go to REPORT with width = number of high samples.
  - `wid_cnt` == TIMEOUT: go to REPORT with TOO_LONG and width = TIMEOUT.
- **REPORT** (one cycle)
  - Assert `meas_valid`; update `latency`, `width`, `err_code` and `pass`; return to IDLE.
  - Error priority: NO_RESP > SPURIOUS > TOO_LONG (width > WIDTH_MAX) > TOO_SHORT (width < WIDTH_MIN) > LATE (latency > LAT_MAX) > OK.
  - `pulse_count` increments, saturating, only when `pass` = 1.
- **enable low:** FSM forced to IDLE and counters cleared on the next edge. No report is issued for an aborted measurement. Result outputs and `pulse_count` hold their values.
- **Counter widths:** `lat_cnt` is 16 bits and `wid_cnt` is 32 bits. Both are bounded by TIMEOUT, so neither wraps.

## Timing
- **Reset values:** `meas_valid` = 0, `latency` = 0, `width` = 0, `pass` = 0, `err_code` = 0, `pulse_count` = 0. FSM in IDLE and both previous-sample registers = 0.
- **Latency definition:** latency = E1 − E0, where E0 is the edge at which the tem rise is detected and E1 is the edge at which the k1 rise is detected.
- **Report timing:** `meas_valid` is asserted on the cycle after the edge at which k1 is first sampled low. Outputs are registered.
- **Back-to-back:** after REPORT the next trigger can be accepted one cycle later. A tem rise during the REPORT cycle is ignored.
- **Reset mid-measurement:** immediate return to reset values. No strobe is issued.

## Configuration
- Macro `K1CHK_SYNC_EN`.
- **Defined:** `tem` and `k1_in` each pass through a 2-flop synchronizer before edge detection. Both paths are delayed by 2 cycles, so latency and width are unchanged. Use this when the inputs come from pins.
- **Undefined:** inputs are used directly and must be synchronous to clk.

## Structure
- Package `k1chk_pkg` holds:
  - the state enum (IDLE, ARMED, HIGH, REPORT);
  - the `err_code` localparams (ERR_OK, ERR_NO_RESP, ERR_TOO_LONG, ERR_TOO_SHORT, ERR_LATE, ERR_SPURIOUS);
  - the counter widths.
- Sub-module `k1chk_edge_det`: optional synchronizer, previous-sample register and rise output. It is instantiated once for tem and once for k1_in.

## Test plan
- Nominal: tem rise at E0, k1 rises at E0+2 and stays high 801 cycles → `meas_valid` once, latency = 2, width = 801, err 0, pass = 1, pulse_count = 1.
- No response: tem rise, k1 held low → report after 4096 cycles with err 1 (NO_RESP), width 0, pass 0, pulse_count unchanged.
- Width limits, three cases:
  - high 790 cycles → err 3 (TOO_SHORT);
  - high 810 cycles → err 2 (TOO_LONG);
  - held high forever → err 2 with width 4096.
- Late and spurious, two cases:
  - k1 at latency 12, width 800 → err 4 (LATE);
  - k1 pulse with no tem → err 5 (SPURIOUS), latency 0.
- Control, three cases:
  - enable dropped mid-HIGH → no strobe and outputs hold;
  - rst_n asserted mid-ARMED → all outputs 0 immediately;
  - pulse_count preloaded near 0xFFFF plus two passes → stays at 0xFFFF.

Source files
------------

// File: rtl/k1chk_pkg.sv
// k1chk_pkg: shared types and constants for the K1 pulse checker.
// Holds the FSM state encoding, the result error codes and the counter widths.
// Imported by k1_pulse_checker and k1chk_edge_det.
package k1chk_pkg;

  // Counter widths: latency counter and K1 high-width counter.
  localparam int LAT_W = 16;
  localparam int WID_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HIGH   = 2'd2,
    ST_REPORT = 2'd3
  } k1chk_state_e;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_NO_RESP   = 3'd1;
  localparam logic [2:0] ERR_TOO_LONG  = 3'd2;
  localparam logic [2:0] ERR_TOO_SHORT = 3'd3;
  localparam logic [2:0] ERR_LATE      = 3'd4;
  localparam logic [2:0] ERR_SPURIOUS  = 3'd5;

  // Result classification in priority order:
  // NO_RESP > SPURIOUS > TOO_LONG > TOO_SHORT > LATE > OK.
  function automatic logic [2:0] k1chk_classify(
    input logic             no_resp,
    input logic             spurious,
    input logic             forced_long,
    input logic [WID_W-1:0] width,
    input logic [LAT_W-1:0] latency,
    input logic [WID_W-1:0] width_min,
    input logic [WID_W-1:0] width_max,
    input logic [LAT_W-1:0] lat_max
  );
    logic [2:0] err;
    if (no_resp)                                 err = ERR_NO_RESP;
    else if (spurious)                           err = ERR_SPURIOUS;
    else if (forced_long || (width > width_max)) err = ERR_TOO_LONG;
    else if (width < width_min)                  err = ERR_TOO_SHORT;
    else if (latency > lat_max)                  err = ERR_LATE;
    else                                         err = ERR_OK;
    return err;
  endfunction

endpackage

// File: rtl/k1chk_edge_det.sv
// k1chk_edge_det: samples one input, keeps the previous sample and flags a rise.
// Ports: clk/rst_n; sig_i raw input; lvl_o current sample; rise_o current=1 & previous=0.
// Build option K1CHK_SYNC_EN inserts a 2-flop synchronizer ahead of the sample.
module k1chk_edge_det
  import k1chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic lvl_o,
  output logic rise_o
);

`ifdef K1CHK_SYNC_EN
  // Pin inputs: two flops before edge detection. Both checker inputs get the
  // same delay, so measured latency and width are unaffected.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sig_i};
  end

  assign lvl_o = sync_q[1];
`else
  // Input already synchronous to clk: the current sample is the input itself.
  assign lvl_o = sig_i;
`endif

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= lvl_o;
  end

  assign rise_o = lvl_o & ~prev_q;

endmodule

// File: rtl/k1_pulse_checker.sv
// k1_pulse_checker: measures TEM-trigger to K1 latency and K1 high width, classifies
// the result and emits a one-cycle meas_valid strobe with registered results.
// Ports: clk/rst_n/enable, tem and k1_in inputs; meas_valid, latency, width, pass,
// err_code, pulse_count outputs. Build option K1CHK_SYNC_EN synchronizes tem/k1_in.
module k1_pulse_checker
  import k1chk_pkg::*;
#(
  parameter int unsigned LAT_MAX   = 8,
  parameter int unsigned WIDTH_MIN = 795,
  parameter int unsigned WIDTH_MAX = 805,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tem,
  input  logic        k1_in,
  output logic        meas_valid,
  output logic [15:0] latency,
  output logic [31:0] width,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [15:0] pulse_count
);

  localparam logic [LAT_W-1:0] TO_LAT    = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] TO_LAT_M1 = LAT_W'(TIMEOUT - 1);
  localparam logic [WID_W-1:0] TO_WID    = WID_W'(TIMEOUT);
  localparam logic [WID_W-1:0] WMIN      = WID_W'(WIDTH_MIN);
  localparam logic [WID_W-1:0] WMAX      = WID_W'(WIDTH_MAX);
  localparam logic [LAT_W-1:0] LMAX      = LAT_W'(LAT_MAX);

  logic unused_tem_lvl;
  logic tem_rise;
  logic k1_lvl;
  logic k1_rise;

  k1chk_edge_det u_tem_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (tem),
    .lvl_o  (unused_tem_lvl),
    .rise_o (tem_rise)
  );

  k1chk_edge_det u_k1_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (k1_in),
    .lvl_o  (k1_lvl),
    .rise_o (k1_rise)
  );

  k1chk_state_e     state_q;
  logic [LAT_W-1:0] lat_cnt_q;   // frozen at the measured latency once in HIGH
  logic [WID_W-1:0] wid_cnt_q;
  logic             spur_q;

  logic             meas_valid_q;
  logic [15:0]      latency_q;
  logic [31:0]      width_q;
  logic             pass_q;
  logic [2:0]       err_code_q;
  logic [15:0]      pulse_count_q;

  // Result of a HIGH-state report. K1 still high here means the stuck-high limit
  // ended the measurement, so width is pinned to TIMEOUT and forced TOO_LONG.
  logic [WID_W-1:0] hi_width;
  logic             hi_forced;
  logic [2:0]       hi_err;

  always_comb begin
    hi_width  = wid_cnt_q;
    hi_forced = 1'b0;
    if (k1_lvl) begin
      hi_width  = TO_WID;
      hi_forced = 1'b1;
    end
    hi_err = k1chk_classify(1'b0, spur_q, hi_forced, hi_width, lat_cnt_q,
                            WMIN, WMAX, LMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= '0;
      wid_cnt_q     <= '0;
      spur_q        <= 1'b0;
      meas_valid_q  <= 1'b0;
      latency_q     <= '0;
      width_q       <= '0;
      pass_q        <= 1'b0;
      err_code_q    <= ERR_OK;
      pulse_count_q <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!enable) begin
        // Abort silently; result registers and pulse_count keep their values.
        state_q   <= ST_IDLE;
        lat_cnt_q <= '0;
        wid_cnt_q <= '0;
        spur_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (k1_rise) begin
              // K1 with a same-edge trigger is a valid zero-latency response;
              // K1 alone is spurious but its width is still measured.
              state_q   <= ST_HIGH;
              lat_cnt_q <= '0;
              wid_cnt_q <= WID_W'(1);
              spur_q    <= ~tem_rise;
            end else if (tem_rise) begin
              state_q   <= ST_ARMED;
              lat_cnt_q <= '0;
              spur_q    <= 1'b0;
            end
          end

          ST_ARMED: begin
            if (k1_rise) begin
              state_q   <= ST_HIGH;
              lat_cnt_q <= lat_cnt_q + LAT_W'(1);
              wid_cnt_q <= WID_W'(1);
            end else if (lat_cnt_q == TO_LAT_M1) begin
              state_q      <= ST_REPORT;
              lat_cnt_q    <= TO_LAT;
              meas_valid_q <= 1'b1;
              latency_q    <= TO_LAT;
              width_q      <= '0;
              err_code_q   <= ERR_NO_RESP;
              pass_q       <= 1'b0;
            end else begin
              lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            end
          end

          ST_HIGH: begin
            if (!k1_lvl || (wid_cnt_q == TO_WID)) begin
              state_q      <= ST_REPORT;
              meas_valid_q <= 1'b1;
              latency_q    <= lat_cnt_q;
              width_q      <= hi_width;
              err_code_q   <= hi_err;
              pass_q       <= (hi_err == ERR_OK);
              if ((hi_err == ERR_OK) && (pulse_count_q != 16'hFFFF))
                pulse_count_q <= pulse_count_q + 16'd1;
            end else begin
              wid_cnt_q <= wid_cnt_q + WID_W'(1);
            end
          end

          // Strobe cycle: any tem rise seen here is dropped.
          ST_REPORT: begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            wid_cnt_q <= '0;
            spur_q    <= 1'b0;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign meas_valid  = meas_valid_q;
  assign latency     = latency_q;
  assign width       = width_q;
  assign pass        = pass_q;
  assign err_code    = err_code_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_k1_pulse_checker.sv
// tb_k1_pulse_checker: directed bench for k1_pulse_checker.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed from the default limits (8 / 795 / 805 / 4096).
module tb_k1_pulse_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tem = 1'b0;
  logic        k1_in = 1'b0;
  logic        meas_valid;
  logic [15:0] latency;
  logic [31:0] width;
  logic        pass;
  logic [2:0]  err_code;
  logic [15:0] pulse_count;

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  k1_pulse_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tem         (tem),
    .k1_in       (k1_in),
    .meas_valid  (meas_valid),
    .latency     (latency),
    .width       (width),
    .pass        (pass),
    .err_code    (err_code),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (meas_valid === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the strobe; n = falling edges waited.
  task automatic wait_report(input string tag, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_valid !== 1'b1 && n < limit);
    chk({tag, "_strobe"}, {31'd0, meas_valid}, 32'd1);
  endtask

  // Trigger (optional), K1 rise lat cycles later, K1 high for wid samples.
  task automatic pulse(input int lat, input int wid, input bit use_tem);
    @(negedge clk);
    if (use_tem) tem = 1'b1;
    repeat (lat) @(negedge clk);
    k1_in = 1'b1;
    repeat (wid) @(negedge clk);
    k1_in = 1'b0;
    tem = 1'b0;
  endtask

  task automatic report_chk(input string tag, input int lat, input int wid,
                            input logic [2:0] err, input logic [15:0] cnt);
    int n;
    wait_report(tag, 2000, n);
    chk({tag, "_delay"}, n, 32'd1);
    chk({tag, "_latency"}, {16'd0, latency}, lat);
    chk({tag, "_width"}, width, wid);
    chk({tag, "_err"}, {29'd0, err_code}, {29'd0, err});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, (err == 3'd0)});
    chk({tag, "_count"}, {16'd0, pulse_count}, {16'd0, cnt});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int s0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, meas_valid}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("rst_latency", {16'd0, latency}, 32'd0);
    chk("rst_width", width, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {29'd0, err_code}, 32'd0);
    chk("rst_count", {16'd0, pulse_count}, 32'd0);

    // Nominal: latency 2, width 801, single-cycle strobe
    pulse(2, 801, 1'b1);
    wait_report("nom", 2000, n);
    chk("nom_delay", n, 32'd1);
    chk("nom_latency", {16'd0, latency}, 32'd2);
    chk("nom_width", width, 32'd801);
    chk("nom_err", {29'd0, err_code}, 32'd0);
    chk("nom_pass", {31'd0, pass}, 32'd1);
    chk("nom_count", {16'd0, pulse_count}, 32'd1);
    @(negedge clk);
    chk("nom_one_cycle", {31'd0, meas_valid}, 32'd0);
    repeat (3) @(negedge clk);

    // No response: trigger only
    @(negedge clk);
    tem = 1'b1;
    wait_report("noresp", 5000, n);
    chk("noresp_wait", {31'd0, (n >= 4096)}, 32'd1);
    chk("noresp_err", {29'd0, err_code}, 32'd1);
    chk("noresp_width", width, 32'd0);
    chk("noresp_pass", {31'd0, pass}, 32'd0);
    chk("noresp_count", {16'd0, pulse_count}, 32'd1);
    tem = 1'b0;
    repeat (3) @(negedge clk);

    // Width limits
    pulse(2, 790, 1'b1);
    report_chk("short", 2, 790, 3'd3, 16'd1);
    pulse(2, 810, 1'b1);
    report_chk("long", 2, 810, 3'd2, 16'd1);

    // K1 stuck high
    @(negedge clk);
    tem = 1'b1;
    repeat (2) @(negedge clk);
    k1_in = 1'b1;
    wait_report("stuck", 5000, n);
    chk("stuck_width", width, 32'd4096);
    chk("stuck_err", {29'd0, err_code}, 32'd2);
    chk("stuck_pass", {31'd0, pass}, 32'd0);
    k1_in = 1'b0;
    tem = 1'b0;
    repeat (3) @(negedge clk);

    // Late and spurious
    pulse(12, 800, 1'b1);
    report_chk("late", 12, 800, 3'd4, 16'd1);
    pulse(0, 800, 1'b0);
    report_chk("spur", 0, 800, 3'd5, 16'd1);

    // Trigger and K1 on the same edge: zero latency, not spurious
    pulse(0, 800, 1'b1);
    report_chk("same_edge", 0, 800, 3'd0, 16'd2);

    // Enable dropped mid-HIGH: no strobe, outputs hold
    s0 = strobes;
    @(negedge clk);
    tem = 1'b1;
    repeat (2) @(negedge clk);
    k1_in = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    k1_in = 1'b0;
    tem = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("en_no_strobe", strobes - s0, 32'd0);
    chk("en_hold_width", width, 32'd800);
    chk("en_hold_err", {29'd0, err_code}, 32'd0);
    chk("en_hold_pass", {31'd0, pass}, 32'd1);
    chk("en_hold_count", {16'd0, pulse_count}, 32'd2);

    // Reset mid-ARMED: outputs return to zero immediately
    s0 = strobes;
    @(negedge clk);
    tem = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, meas_valid}, 32'd0);
    chk("arst_width", width, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_err", {29'd0, err_code}, 32'd0);
    chk("arst_count", {16'd0, pulse_count}, 32'd0);
    tem = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_no_strobe", strobes - s0, 32'd0);

    // pulse_count saturation from a preloaded value
    force dut.pulse_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.pulse_count_q;
    repeat (2) @(negedge clk);
    pulse(3, 800, 1'b1);
    report_chk("sat1", 3, 800, 3'd0, 16'hFFFF);
    pulse(3, 800, 1'b1);
    report_chk("sat2", 3, 800, 3'd0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
